// File: rtl/instruction_fetch_pkg.sv
// ============================================================================
// Module   : instruction_fetch_pkg
// Purpose  : Shared FSM states, buffer sizing and pointer helper for the
//            instruction fetch unit. IFETCH_PREFETCH_EN selects DEPTH=2.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package instruction_fetch_pkg;

  localparam int IF_ADDR_W = 8;
  localparam int IF_DATA_W = 16;

`ifdef IFETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ifetch_buf.sv
// ============================================================================
// Module   : ifetch_buf
// Purpose  : DEPTH-entry FIFO of {pc, ins} with push/pop/flush and occupancy.
//            DEPTH follows IFETCH_PREFETCH_EN via instruction_fetch_pkg.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch_buf
  import instruction_fetch_pkg::*;
#(
  parameter int ADDR_W = IF_ADDR_W,
  parameter int DATA_W = IF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_pc_i,
  input  logic [DATA_W-1:0] push_ins_i,
  input  logic              pop_i,
  output logic [ADDR_W-1:0] head_pc_o,
  output logic [DATA_W-1:0] head_ins_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [ADDR_W-1:0] pc_mem_q  [DEPTH];
  logic [DATA_W-1:0] ins_mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              w_do_push, w_do_pop;

  assign w_do_push = push_i && !flush_i && (count_q != CNT_W'(DEPTH));
  assign w_do_pop  = pop_i  && !flush_i && (count_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (w_do_pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
      if (w_do_push && !w_do_pop)      count_q <= count_q + CNT_W'(1);
      else if (!w_do_push && w_do_pop) count_q <= count_q - CNT_W'(1);
    end
  end

  // Payload storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      pc_mem_q[wr_ptr_q]  <= push_pc_i;
      ins_mem_q[wr_ptr_q] <= push_ins_i;
    end
  end

  assign head_pc_o  = pc_mem_q[rd_ptr_q];
  assign head_ins_o = ins_mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
// ============================================================================
// Module   : instruction_fetch
// Purpose  : Fetches words over a req/ack memory handshake, buffers them and
//            strobes them into the IR. IFETCH_PREFETCH_EN enables prefetch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                ADDR_W   = IF_ADDR_W,
  parameter int                DATA_W   = IF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              ir_ready,
  output logic              ir_load,
  output logic [DATA_W-1:0] ir_ins,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ir_load_q;
  logic [DATA_W-1:0] ir_ins_q;
  logic [ADDR_W-1:0] ir_pc_q;

  logic              w_push, w_pop;
  logic [CNT_W-1:0]  w_count;
  logic [ADDR_W-1:0] w_head_pc;
  logic [DATA_W-1:0] w_head_ins;

  assign w_pop = (w_count != '0) && ir_ready && !redirect;

  ifetch_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (redirect),
    .push_i     (w_push),
    .push_pc_i  (pc_q),
    .push_ins_i (mem_rdata),
    .pop_i      (w_pop),
    .head_pc_o  (w_head_pc),
    .head_ins_o (w_head_ins),
    .count_o    (w_count)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    w_push  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (redirect) begin
          pc_d = redirect_pc;
        end else if (fetch_en && (w_count < CNT_W'(DEPTH))) begin
          state_d = ST_REQ;
          addr_d  = pc_q;
        end
      end
      ST_REQ: begin
        // A redirect without ack leaves a squashed request that must drain.
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = mem_ack ? ST_IDLE : ST_DRAIN;
        end else if (mem_ack) begin
          w_push  = 1'b1;
          pc_d    = pc_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (redirect) pc_d = redirect_pc;
        if (mem_ack)  state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_load_q <= 1'b0;
      ir_ins_q  <= '0;
      ir_pc_q   <= '0;
    end else begin
      ir_load_q <= w_pop;
      if (w_pop) begin
        ir_ins_q <= w_head_ins;
        ir_pc_q  <= w_head_pc;
      end
    end
  end

  assign mem_req  = (state_q != ST_IDLE);
  assign mem_addr = addr_q;
  assign ir_load  = ir_load_q;
  assign ir_ins   = ir_ins_q;
  assign ir_pc    = ir_pc_q;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ============================================================================
// Module   : tb_instruction_fetch
// Purpose  : Directed scoreboard bench for instruction_fetch; honours
//            IFETCH_PREFETCH_EN for the expected buffer depth.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch;

  localparam logic [7:0] RST_PC = 8'h00;
`ifdef IFETCH_PREFETCH_EN
  localparam int TB_DEPTH = 2;
`else
  localparam int TB_DEPTH = 1;
`endif

  typedef struct packed {
    logic [7:0]  pc;
    logic [15:0] ins;
  } exp_t;

  logic        clk, rst_n, fetch_en, mem_ack, ir_ready, redirect;
  logic [7:0]  redirect_pc;
  logic [15:0] mem_rdata;
  logic        mem_req, ir_load;
  logic [7:0]  mem_addr, ir_pc;
  logic [15:0] ir_ins;

  exp_t        exp_q[$];
  logic [7:0]  ld_pc_log[$];
  logic [7:0]  exp_pc, txn_addr;
  int          n_cmp = 0, n_err = 0, n_loads = 0;
  int          ack_delay = 1, wcnt = 0, l0;
  bit          in_txn = 0, stray_req = 0, squash = 0;

  instruction_fetch #(
    .ADDR_W   (8),
    .DATA_W   (16),
    .RESET_PC (RST_PC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_en    (fetch_en),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .ir_ready    (ir_ready),
    .ir_load     (ir_load),
    .ir_ins      (ir_ins),
    .ir_pc       (ir_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    return {a ^ 8'h5A, ~a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fail(input string tag);
    n_cmp++;
    n_err++;
    $error("FAIL %s: observed no/unexpected event, expected correct event", tag);
  endtask

  task automatic wait_loads(input int target, input string tag);
    int k = 0;
    while (n_loads < target && k < 80) begin
      @(negedge clk);
      k++;
    end
    if (n_loads < target) fail(tag);
  endtask

  task automatic wait_req(input string tag);
    int k = 0;
    while (mem_req !== 1'b1 && k < 80) begin
      @(negedge clk);
      k++;
    end
    if (mem_req !== 1'b1) fail(tag);
  endtask

  // Memory responder, IR monitor and scoreboard model (steps just before each edge)
  initial begin : bus
    exp_t e;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    exp_pc    = RST_PC;
    txn_addr  = RST_PC;
    forever begin
      @(negedge clk);
      #1;
      if (ir_load === 1'b1) begin
        n_loads++;
        ld_pc_log.push_back(ir_pc);
        if (exp_q.size() == 0) fail("load_unexpected");
        else begin
          e = exp_q.pop_front();
          chk("ir_pc", {24'h0, ir_pc}, {24'h0, e.pc});
          chk("ir_ins", {16'h0, ir_ins}, {16'h0, e.ins});
        end
      end
      if (!rst_n) begin
        mem_ack = 1'b0;
        in_txn  = 1'b0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (stray_req) begin
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
        stray_req = 1'b0;
      end else if (mem_req === 1'b1) begin
        if (!in_txn) begin
          in_txn   = 1'b1;
          wcnt     = 0;
          txn_addr = exp_pc;
          chk("req_addr", {24'h0, mem_addr}, {24'h0, exp_pc});
        end
        wcnt++;
        if (wcnt >= ack_delay) begin
          chk("addr_stable", {24'h0, mem_addr}, {24'h0, txn_addr});
          mem_ack   = 1'b1;
          mem_rdata = mem_word(txn_addr);
          in_txn    = 1'b0;
        end
      end
      #3;
      if (!rst_n) begin
        exp_q.delete();
        exp_pc = RST_PC;
        squash = 1'b0;
      end else if (redirect) begin
        exp_q.delete();
        exp_pc = redirect_pc;
        if (mem_ack) squash = 1'b0;
        else if (mem_req) squash = 1'b1;
      end else if (mem_ack && mem_req) begin
        if (squash) squash = 1'b0;
        else begin
          e.pc  = exp_pc;
          e.ins = mem_word(exp_pc);
          exp_q.push_back(e);
          exp_pc = exp_pc + 8'd1;
        end
      end
    end
  end

  initial begin : stim
    rst_n = 1'b0; fetch_en = 1'b0; ir_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mem_addr", {24'h0, mem_addr}, {24'h0, RST_PC});
    chk("rst_ir_load", {31'h0, ir_load}, 32'h0);
    chk("rst_ir_ins", {16'h0, ir_ins}, 32'h0);
    chk("rst_ir_pc", {24'h0, ir_pc}, 32'h0);
    rst_n = 1'b1;

    // 1: streaming fetch from reset
    fetch_en = 1'b1; ir_ready = 1'b1; ack_delay = 1;
    wait_loads(3, "t1_timeout");
    fetch_en = 1'b0;
    repeat (12) @(negedge clk);
    chk("t1_pc0", {24'h0, ld_pc_log[0]}, 32'h0);
    chk("t1_pc1", {24'h0, ld_pc_log[1]}, 32'h1);
    chk("t1_pc2", {24'h0, ld_pc_log[2]}, 32'h2);
    chk("t1_idle", {31'h0, mem_req}, 32'h0);

    // 2: back-pressure fills the buffer, then drains in order
    ir_ready = 1'b0; fetch_en = 1'b1; l0 = n_loads;
    repeat (10) @(negedge clk);
    chk("t2_req_low", {31'h0, mem_req}, 32'h0);
    chk("t2_buffered", exp_q.size(), TB_DEPTH);
    chk("t2_noload", n_loads - l0, 0);
    fetch_en = 1'b0; ir_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("t2_delivered", n_loads - l0, TB_DEPTH);

    // 3: redirect while a slow request waits
    ack_delay = 4; fetch_en = 1'b1;
    wait_req("t3_req");
    redirect = 1'b1; redirect_pc = 8'h40; l0 = n_loads;
    @(negedge clk);
    redirect = 1'b0;
    chk("t3_drain_req", {31'h0, mem_req}, 32'h1);
    wait_loads(l0 + 1, "t3_timeout");
    chk("t3_first_pc", {24'h0, ld_pc_log[l0]}, 32'h40);
    fetch_en = 1'b0;
    repeat (15) @(negedge clk);

    // 4: redirect coincident with ack and a pending pop
    ack_delay = 1; ir_ready = 1'b0; fetch_en = 1'b1;
    repeat (8) @(negedge clk);
    ir_ready = 1'b1;
    @(negedge clk);
    ir_ready = 1'b0;
    begin
      int k = 0;
      do begin
        @(negedge clk);
        #2;
        k++;
      end while (mem_ack !== 1'b1 && k < 40);
      if (mem_ack !== 1'b1) fail("t4_ack");
    end
    redirect = 1'b1; redirect_pc = 8'h80; ir_ready = 1'b1; l0 = n_loads;
    @(negedge clk);
    redirect = 1'b0;
    chk("t4_no_load", {31'h0, ir_load}, 32'h0);
    wait_loads(l0 + 1, "t4_timeout");
    chk("t4_first_pc", {24'h0, ld_pc_log[l0]}, 32'h80);
    fetch_en = 1'b0;
    repeat (12) @(negedge clk);

    // 5: address wrap at 0xFF
    redirect = 1'b1; redirect_pc = 8'hFE; fetch_en = 1'b1; l0 = n_loads;
    @(negedge clk);
    redirect = 1'b0;
    wait_loads(l0 + 3, "t5_timeout");
    chk("t5_pc_ff", {24'h0, ld_pc_log[l0 + 1]}, 32'hFF);
    chk("t5_pc_wrap", {24'h0, ld_pc_log[l0 + 2]}, 32'h0);
    fetch_en = 1'b0;
    repeat (12) @(negedge clk);

    // 6: reset mid-transaction, late ack ignored
    ack_delay = 5; fetch_en = 1'b1;
    wait_req("t6_req");
    @(negedge clk);
    rst_n = 1'b0; fetch_en = 1'b0;
    #1;
    chk("t6_mem_req", {31'h0, mem_req}, 32'h0);
    chk("t6_mem_addr", {24'h0, mem_addr}, {24'h0, RST_PC});
    chk("t6_ir_load", {31'h0, ir_load}, 32'h0);
    chk("t6_ir_ins", {16'h0, ir_ins}, 32'h0);
    chk("t6_ir_pc", {24'h0, ir_pc}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; l0 = n_loads;
    @(negedge clk);
    stray_req = 1'b1;
    repeat (6) @(negedge clk);
    chk("t6_stray_ignored", n_loads - l0, 0);
    chk("t6_idle", {31'h0, mem_req}, 32'h0);
    ack_delay = 1; ir_ready = 1'b1; fetch_en = 1'b1;
    wait_loads(l0 + 1, "t6_timeout");
    chk("t6_first_pc", {24'h0, ld_pc_log[l0]}, {24'h0, RST_PC});
    fetch_en = 1'b0;
    repeat (12) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
